mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have no parameters; all widths are fixed (32-bit address/data).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst_req  in  1  fetch read request, held until inst_addr_ok.
REQ-005 inst_addr  in  32  fetch address.
REQ-006 inst_cancel  in  1  pipeline flush; discards any outstanding fetch response.
REQ-007 inst_addr_ok / inst_data_ok  out  1 / 1  fetch address accepted / fetch data valid (one-cycle pulses).
REQ-008 inst_rdata  out  32  fetch data, valid with inst_data_ok.
REQ-009 data_req, data_wr  in  1, 1  load/store request (held until data_addr_ok); data_wr=1 means write.
REQ-010 data_size, data_wstrb  in  2, 4  access size; byte strobes for writes.
REQ-011 data_addr, data_wdata  in  32, 32  load/store address; store data.
REQ-012 data_addr_ok / data_data_ok  out  1 / 1  load/store address accepted / completion (pulses).
REQ-013 data_rdata  out  32  load data, valid with data_data_ok.
REQ-014 bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata  out  1, 1, 2, 4, 32, 32  shared single-port bus request.
REQ-015 bus_addr_ok, bus_data_ok  in  1, 1  bus address accepted; bus response/write-completion valid.
REQ-016 bus_rdata  in  32  bus read data.

Function
REQ-017 FSM states: IDLE, REQ, WAIT.
- IDLE: select a requester and latch its fields. Go to REQ.
- REQ: drive bus_req=1 with the latched fields. On bus_addr_ok, pulse the owner's *_addr_ok in the same cycle and go to WAIT.
- WAIT: on bus_data_ok, route the response and go to IDLE.
REQ-018 Only one transaction SHALL be outstanding; no new grant until WAIT exits, giving at least 1 idle cycle between grants.
REQ-019 Owner tag (INST/DATA) SHALL be latched at grant; responses route only to the tagged owner, and the other *_data_ok stays 0.
REQ-020 Fixed priority (macro absent): data SHALL win when both requests are asserted in IDLE.
REQ-021 Inst grants SHALL force bus_wr=0, bus_size=2'b10, bus_wstrb=4'h0.
REQ-022 Latched bus_* fields SHALL stay stable from entering REQ until bus_addr_ok, independent of requester inputs.
REQ-023 inst_cancel while the INST owner is in REQ or WAIT SHALL set a discard flag.
- Matching bus_data_ok SHALL be consumed with inst_data_ok=0.
- The flag clears on that bus_data_ok.
REQ-024 inst_cancel in REQ before bus_addr_ok SHALL NOT withdraw bus_req; the transaction completes and is discarded.
REQ-025 inst_cancel SHALL NOT affect DATA-owned transactions.
REQ-026 bus_addr_ok and bus_data_ok in the same REQ cycle (zero-latency slave) SHALL complete the transaction: both pulses issued, return to IDLE.
REQ-027 bus_data_ok seen in IDLE SHALL be ignored.
REQ-028 inst_rdata/data_rdata SHALL be driven combinationally from bus_rdata.

Reset
REQ-029 On reset the arbiter SHALL enter IDLE and clear the discard flag, owner tag and round-robin pointer (pointer = INST last served).
REQ-030 All outputs SHALL be 0 during and after reset until the first grant.
REQ-031 Reset mid-transaction SHALL abandon it with no pulses.

Configuration
REQ-032 Macro ARB_ROUND_ROBIN_EN selects the IDLE-state tie-break.
- Defined: on simultaneous requests, grant the requester not served last; a 1-bit pointer updates at each grant.
- Undefined: fixed data-first priority; the pointer logic is absent.

Verification
REQ-033 Single fetch: inst_req, addr 0xbfc00000, bus_addr_ok 1 cycle after bus_req, bus_data_ok 2 cycles later with rdata 0x3c1d0001 -> one inst_addr_ok, one inst_data_ok with 0x3c1d0001, bus_wr=0.
REQ-034 Conflict: inst_req and data_req (store, addr 0x80000010, wstrb 0xF, wdata 0x12345678) asserted together ->
- Macro off: store granted first, fetch second.
- Macro on: store first, and the next tie goes to fetch.
REQ-035 Flush: fetch granted, inst_cancel in WAIT, then bus_data_ok -> no inst_data_ok; the next fetch to 0xbfc00380 returns data normally.
REQ-036 Zero-latency slave: bus_addr_ok and bus_data_ok in the same cycle for a load -> data_addr_ok and data_data_ok pulse together, FSM returns to IDLE.
REQ-037 Reset asserted in WAIT -> all outputs 0 the next cycle, and the stale bus_data_ok after reset produces no pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and shared-bus handshake signals for mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// requester/bus-slave side (pipeline plus memory bus).
interface mem_port_arbiter_if;
  // fetch port
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // load/store port
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // shared bus
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates fetch and load/store requests onto one single-outstanding memory bus.
// Latency: 1 cycle from request to bus_req; addr_ok/data_ok pass through combinationally from the bus.
// Backpressure: requests held until *_addr_ok; no new grant until the response returns.
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie-break (default: data-first priority).
module mem_port_arbiter (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave port
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Owner of the current transaction: 0 = fetch, 1 = load/store.
  logic        owner_data;
  // Set when the in-flight fetch was flushed; its response is swallowed.
  logic        discard;

  logic        wr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        grant;
  logic        grant_data;
  logic        addr_acc;
  logic        xfer_done;
  logic        inst_dok;
  logic        data_dok;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when load/store was served by the most recent grant.
  logic        last_data;
`endif

  // Pick the winner among the requesters seen in IDLE.
  always_comb begin
    grant = port.inst_req | port.data_req;
`ifdef ARB_ROUND_ROBIN_EN
    grant_data = port.data_req & (~port.inst_req | ~last_data);
`else
    grant_data = port.data_req;
`endif
  end

  // Address acceptance and completion; a zero-latency slave completes inside REQ.
  always_comb begin
    addr_acc  = (state == REQ) & port.bus_addr_ok;
    xfer_done = ((state == REQ) & port.bus_addr_ok & port.bus_data_ok) |
                ((state == WAIT) & port.bus_data_ok);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant) state_next = REQ;
      REQ: begin
        if (port.bus_addr_ok) begin
          state_next = port.bus_data_ok ? IDLE : WAIT;
        end
      end
      WAIT: if (port.bus_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's fields and owner tag at grant; they stay frozen until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_data <= 1'b0;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      wstrb_q    <= 4'h0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else if (state == IDLE && grant) begin
      owner_data <= grant_data;
      if (grant_data) begin
        wr_q    <= port.data_wr;
        size_q  <= port.data_size;
        wstrb_q <= port.data_wstrb;
        addr_q  <= port.data_addr;
        wdata_q <= port.data_wdata;
      end else begin
        wr_q    <= 1'b0;
        size_q  <= 2'b10;
        wstrb_q <= 4'h0;
        addr_q  <= port.inst_addr;
        wdata_q <= 32'h0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember who was served last so the next tie goes to the other side.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_data <= 1'b0;
    end else if (state == IDLE && grant) begin
      last_data <= grant_data;
    end
  end
`endif

  // Flush tracking: cleared when the owning transaction completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (xfer_done) begin
      discard <= 1'b0;
    end else if (port.inst_cancel && !owner_data && state != IDLE) begin
      discard <= 1'b1;
    end
  end

  // Outputs: pulses routed by owner tag; everything held at zero while reset is high.
  always_comb begin
    inst_dok          = xfer_done & ~owner_data & ~discard & ~port.inst_cancel;
    data_dok          = xfer_done & owner_data;
    port.bus_req      = 1'b0;
    port.bus_wr       = 1'b0;
    port.bus_size     = 2'b00;
    port.bus_wstrb    = 4'h0;
    port.bus_addr     = 32'h0;
    port.bus_wdata    = 32'h0;
    port.inst_addr_ok = 1'b0;
    port.inst_data_ok = 1'b0;
    port.inst_rdata   = 32'h0;
    port.data_addr_ok = 1'b0;
    port.data_data_ok = 1'b0;
    port.data_rdata   = 32'h0;
    if (!reset) begin
      port.bus_req      = (state == REQ);
      port.bus_wr       = wr_q;
      port.bus_size     = size_q;
      port.bus_wstrb    = wstrb_q;
      port.bus_addr     = addr_q;
      port.bus_wdata    = wdata_q;
      port.inst_addr_ok = addr_acc & ~owner_data;
      port.data_addr_ok = addr_acc & owner_data;
      port.inst_data_ok = inst_dok;
      port.data_data_ok = data_dok;
      port.inst_rdata   = inst_dok ? port.bus_rdata : 32'h0;
      port.data_rdata   = data_dok ? port.bus_rdata : 32'h0;
    end
  end

endmodule
